di_arbiter: RTL and testbench

Two-requester arbiter that shares the device-interface register bus (endpoint address, register address, write data, write/read strobes, read data, `rdwr_ready`) between the host-interface port and a second on-chip master such as a local sequencer or boot loader. It sits between the host interface's `di*` outputs and the endpoint/register decoders. It captures single-cycle write and read requests from each side, serialises them with round-robin priority, and returns read data with a one-cycle ready pulse to the requester that issued the read.

---
 rtl/di_arbiter.sv | 157 +++++++++++++++
 tb/tb_di_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/di_arbiter.sv
// di_arbiter: round-robin arbiter sharing the device-interface register bus between two masters.
// Defining DI_ARB_TIMEOUT_EN adds a read timeout that completes stalled reads with 16'hDEAD.
module di_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        if_clock,
  input  logic        resetb,
  input  logic [15:0] r0EpAddr,
  input  logic [15:0] r0RegAddr,
  input  logic [15:0] r0RegDataIn,
  input  logic        r0Write,
  input  logic        r0Read,
  output logic [15:0] r0RegDataOut,
  output logic        r0Ready,
  input  logic [15:0] r1EpAddr,
  input  logic [15:0] r1RegAddr,
  input  logic [15:0] r1RegDataIn,
  input  logic        r1Write,
  input  logic        r1Read,
  output logic [15:0] r1RegDataOut,
  output logic        r1Ready,
  output logic [15:0] diEpAddr,
  output logic [15:0] diRegAddr,
  output logic [15:0] diRegDataIn,
  output logic        diWrite,
  output logic        diRead,
  input  logic [15:0] diRegDataOut,
  input  logic        rdwr_ready,
  output logic        grant,
  output logic        busy,
  output logic [1:0]  overrun,
  output logic        timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [1:0]  v_q, v_d, op_q, op_d, rdy_q, rdy_d, ovr_q, ovr_d;
  logic [47:0] f_q [2];
  logic [47:0] f_d [2];
  logic [47:0] fin [2];
  logic [15:0] dout_q [2];
  logic [15:0] dout_d [2];
  logic [47:0] di_q, di_d;
  logic        diw_q, diw_d, dir_q, dir_d, grant_q, grant_d, last_q, last_d;
  logic [1:0]  req, wr;
  logic        sel, done, tmo, own_wr;

  assign fin[0] = {r0EpAddr, r0RegAddr, r0RegDataIn};
  assign fin[1] = {r1EpAddr, r1RegAddr, r1RegDataIn};
  assign req    = {r1Write | r1Read, r0Write | r0Read};
  assign wr     = {r1Write, r0Write};
  assign sel    = &v_q ? ~last_q : v_q[1];
  assign own_wr = op_q[grant_q];
  assign done   = (state_q == ISSUE && (own_wr || rdwr_ready)) ||
                  (state_q == WAIT_RD && (rdwr_ready || tmo));

`ifdef DI_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        terr_q, terr_d;
  assign tmo = state_q == WAIT_RD && !rdwr_ready && cnt_q == 16'(TIMEOUT_CYCLES - 1);
  always_comb begin
    cnt_d  = state_q == WAIT_RD ? cnt_q + 16'd1 : 16'd0;
    terr_d = terr_q | tmo;
  end
  always_ff @(posedge if_clock or negedge resetb)
    if (!resetb) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  assign timeout_err = terr_q;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A slot freed by the completing transaction may accept a new request on the same edge.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      v_d[i]   = v_q[i] & ~(done && grant_q == 1'(i));
      op_d[i]  = op_q[i];
      f_d[i]   = f_q[i];
      ovr_d[i] = ovr_q[i] | (req[i] & v_d[i]);
      if (req[i] && !v_d[i]) begin
        v_d[i]  = 1'b1;
        op_d[i] = wr[i];
        f_d[i]  = fin[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    di_d    = di_q;
    diw_d   = 1'b0;
    dir_d   = 1'b0;
    rdy_d   = 2'b00;
    dout_d  = dout_q;
    if (state_q == IDLE && |v_q) begin
      state_d = ISSUE;
      grant_d = sel;
      last_d  = sel;
      di_d    = f_q[sel];
      diw_d   = op_q[sel];
      dir_d   = ~op_q[sel];
    end
    if (state_q == ISSUE && !done) state_d = WAIT_RD;
    if (done) begin
      state_d = IDLE;
      rdy_d   = grant_q ? 2'b10 : 2'b01;
      if (!own_wr) dout_d[grant_q] = tmo ? 16'hDEAD : diRegDataOut;
    end
  end

  always_ff @(posedge if_clock or negedge resetb)
    if (!resetb) begin
      state_q <= IDLE;
      v_q     <= '0;
      op_q    <= '0;
      f_q     <= '{default: '0};
      ovr_q   <= '0;
      rdy_q   <= '0;
      dout_q  <= '{default: '0};
      di_q    <= '0;
      diw_q   <= 1'b0;
      dir_q   <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      op_q    <= op_d;
      f_q     <= f_d;
      ovr_q   <= ovr_d;
      rdy_q   <= rdy_d;
      dout_q  <= dout_d;
      di_q    <= di_d;
      diw_q   <= diw_d;
      dir_q   <= dir_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end

  assign {diEpAddr, diRegAddr, diRegDataIn} = di_q;
  assign diWrite      = diw_q;
  assign diRead       = dir_q;
  assign r0RegDataOut = dout_q[0];
  assign r1RegDataOut = dout_q[1];
  assign r0Ready      = rdy_q[0];
  assign r1Ready      = rdy_q[1];
  assign grant        = grant_q;
  assign busy         = state_q != IDLE;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_di_arbiter.sv
// tb_di_arbiter: directed checks of di_arbiter capture, arbitration, read return, overrun and reset.
module tb_di_arbiter;
  logic        if_clock = 1'b0, resetb = 1'b0;
  logic [15:0] r0EpAddr = '0, r0RegAddr = '0, r0RegDataIn = '0;
  logic [15:0] r1EpAddr = '0, r1RegAddr = '0, r1RegDataIn = '0;
  logic        r0Write = 1'b0, r0Read = 1'b0, r1Write = 1'b0, r1Read = 1'b0;
  logic [15:0] diRegDataOut = '0;
  logic        rdwr_ready = 1'b0;
  logic [15:0] r0RegDataOut, r1RegDataOut, diEpAddr, diRegAddr, diRegDataIn;
  logic        r0Ready, r1Ready, diWrite, diRead, grant, busy, timeout_err;
  logic [1:0]  overrun;
  int n_cmp = 0, n_bad = 0;
  int r0_pulses = 0, r1_pulses = 0, r1_writes = 0;

  di_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .if_clock(if_clock), .resetb(resetb),
    .r0EpAddr(r0EpAddr), .r0RegAddr(r0RegAddr), .r0RegDataIn(r0RegDataIn),
    .r0Write(r0Write), .r0Read(r0Read), .r0RegDataOut(r0RegDataOut), .r0Ready(r0Ready),
    .r1EpAddr(r1EpAddr), .r1RegAddr(r1RegAddr), .r1RegDataIn(r1RegDataIn),
    .r1Write(r1Write), .r1Read(r1Read), .r1RegDataOut(r1RegDataOut), .r1Ready(r1Ready),
    .diEpAddr(diEpAddr), .diRegAddr(diRegAddr), .diRegDataIn(diRegDataIn),
    .diWrite(diWrite), .diRead(diRead), .diRegDataOut(diRegDataOut), .rdwr_ready(rdwr_ready),
    .grant(grant), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 if_clock = ~if_clock;

  always @(posedge if_clock) begin
    if (r0Ready) r0_pulses <= r0_pulses + 1;
    if (r1Ready) r1_pulses <= r1_pulses + 1;
    if (diWrite && grant) r1_writes <= r1_writes + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge if_clock);
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    tick(2);
    n_cmp++; if ({diWrite, diRead, grant, busy, r0Ready, r1Ready, timeout_err} !== 7'd0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0000000", {diWrite, diRead, grant, busy, r0Ready, r1Ready, timeout_err}); end
    n_cmp++; if (overrun !== 2'b00) begin n_bad++; $display("FAIL reset_overrun: got %b want 00", overrun); end
    n_cmp++; if ({diEpAddr, diRegAddr, diRegDataIn, r0RegDataOut, r1RegDataOut} !== 80'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {diEpAddr, diRegAddr, diRegDataIn, r0RegDataOut, r1RegDataOut}); end
    resetb = 1'b1;
    tick();
  endtask

  task automatic test_write;
    r0Write = 1'b1; r0EpAddr = 16'h0003; r0RegAddr = 16'h0010; r0RegDataIn = 16'hA5A5;
    tick();
    r0Write = 1'b0;
    n_cmp++; if (diWrite !== 1'b0) begin n_bad++; $display("FAIL wr_e0_strobe: got %b want 0", diWrite); end
    tick();
    n_cmp++; if ({diWrite, diRead, grant, busy, r0Ready} !== 5'b10010) begin n_bad++; $display("FAIL wr_e1_ctrl: got %b want 10010", {diWrite, diRead, grant, busy, r0Ready}); end
    n_cmp++; if ({diEpAddr, diRegAddr, diRegDataIn} !== 48'h0003_0010_A5A5) begin n_bad++; $display("FAIL wr_e1_fields: got %h want 00030010a5a5", {diEpAddr, diRegAddr, diRegDataIn}); end
    tick();
    n_cmp++; if ({diWrite, r0Ready, r1Ready, busy} !== 4'b0100) begin n_bad++; $display("FAIL wr_e2_ready: got %b want 0100", {diWrite, r0Ready, r1Ready, busy}); end
    tick();
    n_cmp++; if (r0Ready !== 1'b0 || diEpAddr !== 16'h0003) begin n_bad++; $display("FAIL wr_e3_hold: got rdy=%b ep=%h want 0 0003", r0Ready, diEpAddr); end
  endtask

  task automatic test_write_read_same;
    r1Write = 1'b1; r1Read = 1'b1; r1EpAddr = 16'h0007; r1RegAddr = 16'h0008; r1RegDataIn = 16'hBEEF;
    tick();
    r1Write = 1'b0; r1Read = 1'b0;
    tick();
    n_cmp++; if ({diWrite, diRead, grant} !== 3'b101) begin n_bad++; $display("FAIL wr_rd_same: got %b want 101", {diWrite, diRead, grant}); end
    tick();
    n_cmp++; if ({r0Ready, r1Ready} !== 2'b01) begin n_bad++; $display("FAIL wr_rd_ready: got %b want 01", {r0Ready, r1Ready}); end
    tick();
  endtask

  task automatic test_read_contention;
    int p0, p1;
    p0 = r0_pulses; p1 = r1_pulses;
    r0Read = 1'b1; r0EpAddr = 16'h0001; r0RegAddr = 16'h0021;
    r1Read = 1'b1; r1EpAddr = 16'h0002; r1RegAddr = 16'h0031;
    tick();
    r0Read = 1'b0; r1Read = 1'b0;
    tick();
    n_cmp++; if ({diRead, grant, diRegAddr} !== {1'b1, 1'b0, 16'h0021}) begin n_bad++; $display("FAIL rd_first_grant: got rd=%b g=%b reg=%h want 1 0 0021", diRead, grant, diRegAddr); end
    tick();
    n_cmp++; if ({busy, r0Ready, diRead} !== 3'b100) begin n_bad++; $display("FAIL rd_wait: got %b want 100", {busy, r0Ready, diRead}); end
    tick();
    rdwr_ready = 1'b1; diRegDataOut = 16'h1234;
    tick();
    rdwr_ready = 1'b0; diRegDataOut = 16'h0000;
    n_cmp++; if ({r0Ready, r1Ready, r0RegDataOut} !== {2'b10, 16'h1234}) begin n_bad++; $display("FAIL rd0_done: got r0=%b r1=%b d=%h want 1 0 1234", r0Ready, r1Ready, r0RegDataOut); end
    tick();
    n_cmp++; if ({diRead, grant, r0Ready, diRegAddr} !== {3'b110, 16'h0031}) begin n_bad++; $display("FAIL rd_second_grant: got rd=%b g=%b r0=%b reg=%h want 1 1 0 0031", diRead, grant, r0Ready, diRegAddr); end
    tick(2);
    rdwr_ready = 1'b1; diRegDataOut = 16'h5678;
    tick();
    rdwr_ready = 1'b0; diRegDataOut = 16'h0000;
    n_cmp++; if ({r0Ready, r1Ready, r1RegDataOut, r0RegDataOut} !== {2'b01, 16'h5678, 16'h1234}) begin n_bad++; $display("FAIL rd1_done: got r0=%b r1=%b d1=%h d0=%h want 0 1 5678 1234", r0Ready, r1Ready, r1RegDataOut, r0RegDataOut); end
    tick(2);
    n_cmp++; if (r0_pulses - p0 !== 1 || r1_pulses - p1 !== 1) begin n_bad++; $display("FAIL rd_pulse_count: got %0d/%0d want 1/1", r0_pulses - p0, r1_pulses - p1); end
  endtask

  task automatic test_round_robin;
    logic [6:0] exp_g;
    int k, w0, n1, p0, p1;
    exp_g = 7'b0101010;
    k = 0; w0 = 1; n1 = 1; p0 = r0_pulses; p1 = r1_pulses;
    rdwr_ready = 1'b1; diRegDataOut = 16'hC0DE;
    r0Write = 1'b1; r0EpAddr = 16'h0100; r1Read = 1'b1; r1EpAddr = 16'h0200;
    for (int c = 0; c < 40 && k < 7; c++) begin
      tick();
      r0Write = 1'b0; r1Read = 1'b0;
      if (diWrite || diRead) begin
        n_cmp++; if (grant !== exp_g[k]) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", k, grant, exp_g[k]); end
        k++;
        if (!grant && w0 < 4) begin r0Write = 1'b1; w0++; end
        if (grant && n1 < 3) begin r1Read = 1'b1; n1++; end
      end
    end
    n_cmp++; if (k !== 7) begin n_bad++; $display("FAIL rr_issue_count: got %0d want 7", k); end
    tick(3);
    rdwr_ready = 1'b0; diRegDataOut = 16'h0000;
    n_cmp++; if (overrun !== 2'b00 || r1RegDataOut !== 16'hC0DE) begin n_bad++; $display("FAIL rr_end: got ovr=%b d1=%h want 00 c0de", overrun, r1RegDataOut); end
    n_cmp++; if (r0_pulses - p0 !== 4 || r1_pulses - p1 !== 3) begin n_bad++; $display("FAIL rr_pulses: got %0d/%0d want 4/3", r0_pulses - p0, r1_pulses - p1); end
  endtask

  task automatic test_overrun;
    int c;
    c = r1_writes;
    r1Write = 1'b1; r1EpAddr = 16'h0050; r1RegDataIn = 16'h1111;
    tick();
    r1RegDataIn = 16'h2222;
    tick();
    r1Write = 1'b0;
    n_cmp++; if ({overrun, diWrite, grant, diRegDataIn} !== {4'b1011, 16'h1111}) begin n_bad++; $display("FAIL ovr_first: got ovr=%b w=%b g=%b d=%h want 10 1 1 1111", overrun, diWrite, grant, diRegDataIn); end
    tick(4);
    n_cmp++; if (r1_writes - c !== 1 || overrun !== 2'b10) begin n_bad++; $display("FAIL ovr_single: got writes=%0d ovr=%b want 1 10", r1_writes - c, overrun); end
  endtask

  task automatic test_reset_mid;
    int p0;
    r0Read = 1'b1; r0EpAddr = 16'h0060;
    tick();
    r0Read = 1'b0;
    tick(2);
    n_cmp++; if (busy !== 1'b1 || diRead !== 1'b0) begin n_bad++; $display("FAIL mid_wait: got busy=%b rd=%b want 1 0", busy, diRead); end
    p0 = r0_pulses;
    #2 resetb = 1'b0;
    #1;
    n_cmp++; if ({busy, grant, overrun, diRead, diWrite, r0Ready} !== 7'd0) begin n_bad++; $display("FAIL mid_ctrl: got %b want 0000000", {busy, grant, overrun, diRead, diWrite, r0Ready}); end
    n_cmp++; if ({diEpAddr, r0RegDataOut, r1RegDataOut} !== 48'd0) begin n_bad++; $display("FAIL mid_data: got %h want 0", {diEpAddr, r0RegDataOut, r1RegDataOut}); end
    rdwr_ready = 1'b1; diRegDataOut = 16'h9999;
    tick(3);
    n_cmp++; if (r0_pulses !== p0 || r0RegDataOut !== 16'h0000) begin n_bad++; $display("FAIL mid_no_ready: got pulses=%0d d=%h want %0d 0000", r0_pulses, r0RegDataOut, p0); end
    rdwr_ready = 1'b0; diRegDataOut = 16'h0000;
    resetb = 1'b1;
    tick();
    r0Write = 1'b1; r0EpAddr = 16'h0070; r1Write = 1'b1; r1EpAddr = 16'h0071;
    tick();
    r0Write = 1'b0; r1Write = 1'b0;
    tick();
    n_cmp++; if ({diWrite, grant, diEpAddr} !== {2'b10, 16'h0070}) begin n_bad++; $display("FAIL cold_first: got w=%b g=%b ep=%h want 1 0 0070", diWrite, grant, diEpAddr); end
    tick(2);
    n_cmp++; if ({diWrite, grant, diEpAddr} !== {2'b11, 16'h0071}) begin n_bad++; $display("FAIL cold_second: got w=%b g=%b ep=%h want 1 1 0071", diWrite, grant, diEpAddr); end
    tick(2);
  endtask

`ifdef DI_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit seen;
    seen = 1'b0;
    r0Read = 1'b1;
    tick();
    r0Read = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = r0Ready;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL tmo_ready: got no r0Ready want pulse"); end
    n_cmp++; if ({r0RegDataOut, timeout_err, busy} !== {16'hDEAD, 2'b10}) begin n_bad++; $display("FAIL tmo_state: got d=%h err=%b busy=%b want dead 1 0", r0RegDataOut, timeout_err, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_write_read_same();
    test_read_contention();
    test_round_robin();
    test_overrun();
    test_reset_mid();
`ifdef DI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
